// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int RF_WBQ_DEPTH = 4;

  typedef logic [4:0] rf_add;

  function automatic logic is_x0(input rf_add a);
    return (a == 5'd0);
  endfunction

endpackage

// File: rtl/rf_wbq_fifo.sv
// Deferred multicycle write queue: DEPTH entries of {address, value}.
module rf_wbq_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = RF_WBQ_DEPTH,
  parameter int W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  rf_add                  add_i,
  input  logic [W-1:0]           val_i,
  input  logic                   pop_i,
  output rf_add                  head_add_o,
  output logic [W-1:0]           head_val_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  rf_add          add_mem [DEPTH];
  logic [W-1:0]   val_mem [DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_add_o = add_mem[rd_q];
  assign head_val_o = val_mem[rd_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer wrap is the natural overflow.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      add_mem[wr_q] <= add_i;
      val_mem[wr_q] <= val_i;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges the in-order pipeline result and a multicycle-unit result onto the
// register-file write port; tracks registers reserved by in-flight multicycle ops.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = RF_WBQ_DEPTH,
  parameter int W     = 32
) (
  input  logic         s_clk_i,
  input  logic         s_resetn_i,
  input  logic         s_pw_we_i,
  input  rf_add        s_pw_add_i,
  input  logic [W-1:0] s_pw_val_i,
  input  logic         s_aw_valid_i,
  output logic         s_aw_ready_o,
  input  rf_add        s_aw_add_i,
  input  logic [W-1:0] s_aw_val_i,
  input  logic         s_rsv_i,
  input  rf_add        s_rsv_add_i,
  output logic         s_wb_we_o,
  output rf_add        s_wb_add_o,
  output logic [W-1:0] s_wb_val_o,
  output logic [31:0]  s_busy_o,
  output logic         s_full_o,
  output logic         s_err_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic          full, empty;
  rf_add         head_add;
  logic [W-1:0]  head_val;
  logic          xfer, push, pop, sel;
  rf_add         sel_add;
  logic [W-1:0]  sel_val;

  logic          wb_we_q, wb_we_d;
  rf_add         wb_add_q, wb_add_d;
  logic [W-1:0]  wb_val_q, wb_val_d;
  logic [31:0]   busy_q, busy_d;
  logic          err_q, err_d;

  // Handshake: ready depends only on the registered FIFO count; a transfer is
  // valid && ready, and the source holds valid/add/val stable until it happens.
  assign s_aw_ready_o = (count < CW'(DEPTH));
  assign xfer         = s_aw_valid_i && s_aw_ready_o;

  rf_wbq_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk_i      (s_clk_i),
    .rst_ni     (s_resetn_i),
    .push_i     (push),
    .add_i      (s_aw_add_i),
    .val_i      (s_aw_val_i),
    .pop_i      (pop),
    .head_add_o (head_add),
    .head_val_o (head_val),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty)
  );

  // Pipeline first, then queued results, then a direct bypass.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    sel     = 1'b0;
    sel_add = s_pw_add_i;
    sel_val = s_pw_val_i;
    if (s_pw_we_i) begin
      sel  = 1'b1;
      push = xfer;
    end else if (!empty) begin
      sel     = 1'b1;
      pop     = 1'b1;
      push    = xfer;
      sel_add = head_add;
      sel_val = head_val;
    end else if (xfer) begin
      sel     = 1'b1;
      sel_add = s_aw_add_i;
      sel_val = s_aw_val_i;
    end
  end

  always_comb begin
    wb_we_d  = sel && !is_x0(sel_add);
    wb_add_d = sel ? sel_add : wb_add_q;
    wb_val_d = sel ? sel_val : wb_val_q;
  end

  // Clear before set so a same-cycle re-reservation survives the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (xfer) busy_d[s_aw_add_i] = 1'b0;
    if (s_rsv_i && !is_x0(s_rsv_add_i)) busy_d[s_rsv_add_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (s_rsv_i && !is_x0(s_rsv_add_i) && busy_q[s_rsv_add_i] &&
        !(xfer && (s_aw_add_i == s_rsv_add_i)))
      err_d = 1'b1;
    if (s_pw_we_i && busy_q[s_pw_add_i]) err_d = 1'b1;
    if (xfer && !busy_q[s_aw_add_i])     err_d = 1'b1;
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      wb_we_q  <= 1'b0;
      wb_add_q <= '0;
      wb_val_q <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wb_we_q  <= wb_we_d;
      wb_add_q <= wb_add_d;
      wb_val_q <= wb_val_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign s_wb_we_o  = wb_we_q;
  assign s_wb_add_o = wb_add_q;
  assign s_wb_val_o = wb_val_q;
  assign s_busy_o   = busy_q;
  assign s_full_o   = full;
  assign s_err_o    = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: queue-based reference model drives an
// expected-write queue that a negedge monitor drains against the DUT.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_pw_we_i = 1'b0;
  logic [4:0]   s_pw_add_i = '0;
  logic [W-1:0] s_pw_val_i = '0;
  logic         s_aw_valid_i = 1'b0;
  logic         s_aw_ready_o;
  logic [4:0]   s_aw_add_i = '0;
  logic [W-1:0] s_aw_val_i = '0;
  logic         s_rsv_i = 1'b0;
  logic [4:0]   s_rsv_add_i = '0;
  logic         s_wb_we_o;
  logic [4:0]   s_wb_add_o;
  logic [W-1:0] s_wb_val_o;
  logic [31:0]  s_busy_o;
  logic         s_full_o;
  logic         s_err_o;

  rf_wb_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
    .s_clk_i      (clk),
    .s_resetn_i   (rst_n),
    .s_pw_we_i    (s_pw_we_i),
    .s_pw_add_i   (s_pw_add_i),
    .s_pw_val_i   (s_pw_val_i),
    .s_aw_valid_i (s_aw_valid_i),
    .s_aw_ready_o (s_aw_ready_o),
    .s_aw_add_i   (s_aw_add_i),
    .s_aw_val_i   (s_aw_val_i),
    .s_rsv_i      (s_rsv_i),
    .s_rsv_add_i  (s_rsv_add_i),
    .s_wb_we_o    (s_wb_we_o),
    .s_wb_add_o   (s_wb_add_o),
    .s_wb_val_o   (s_wb_val_o),
    .s_busy_o     (s_busy_o),
    .s_full_o     (s_full_o),
    .s_err_o      (s_err_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks   = 0;
  int failures = 0;

  logic [W+4:0] exp_q[$];     // expected {add,val} of every write with we=1
  logic [W+4:0] mq[$];        // model of deferred results
  logic [W+4:0] aux_todo[$];  // aux results waiting to be offered
  logic [4:0]   rsv_list[$];  // random phase: reserved, not yet offered
  logic         aux_pend = 1'b0;
  logic [W+4:0] aux_cur  = '0;
  logic [31:0]  busy_m = '0, busy_nx = '0;
  logic         err_m = 1'b0, err_nx = 1'b0;
  logic         mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus; the model computes what the port must show next cycle.
  task automatic cycle(input logic pw, input logic [4:0] pa, input logic [W-1:0] pv,
                       input logic rsv, input logic [4:0] ra);
    logic         ready_m, xfer;
    logic [W+4:0] h;
    logic [31:0]  b;
    logic [4:0]   xa;
    @(posedge clk); #1;
    busy_m = busy_nx;
    err_m  = err_nx;
    ready_m = (mq.size() < DEPTH);
    chk("aw_ready", s_aw_ready_o, ready_m);
    chk("full", s_full_o, mq.size() == DEPTH);
    if (!aux_pend && aux_todo.size() > 0) begin
      aux_cur  = aux_todo.pop_front();
      aux_pend = 1'b1;
    end
    s_pw_we_i    = pw;
    s_pw_add_i   = pa;
    s_pw_val_i   = pv;
    s_rsv_i      = rsv;
    s_rsv_add_i  = ra;
    s_aw_valid_i = aux_pend;
    s_aw_add_i   = aux_cur[W+4:W];
    s_aw_val_i   = aux_cur[W-1:0];
    xfer = aux_pend && ready_m;
    xa   = aux_cur[W+4:W];
    if (pw) begin
      if (pa != 5'd0) exp_q.push_back({pa, pv});
      if (xfer) mq.push_back(aux_cur);
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h[W+4:W] != 5'd0) exp_q.push_back(h);
      if (xfer) mq.push_back(aux_cur);
    end else if (xfer) begin
      if (xa != 5'd0) exp_q.push_back(aux_cur);
    end
    err_nx = err_m
           | (rsv && ra != 5'd0 && busy_m[ra] && !(xfer && xa == ra))
           | (pw && busy_m[pa])
           | (xfer && !busy_m[xa]);
    b = busy_m;
    if (xfer) b[xa] = 1'b0;
    if (rsv && ra != 5'd0) b[ra] = 1'b1;
    busy_nx = b;
    if (xfer) aux_pend = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, '0, 1'b0, 5'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W+4:0] e;
    if (mon_en) begin
      chk("busy", s_busy_o, busy_m);
      chk("err", s_err_o, err_m);
      if (s_wb_we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=x%0d:%0h required=no_write t=%0t",
                   s_wb_add_o, s_wb_val_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("wb_add", s_wb_add_o, e[W+4:W]);
          chk("wb_val", s_wb_val_o, e[W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] r;
    // Reset state with idle inputs.
    #12;
    chk("rst_we", s_wb_we_o, 0);
    chk("rst_add", s_wb_add_o, 0);
    chk("rst_val", s_wb_val_o, 0);
    chk("rst_busy", s_busy_o, 0);
    chk("rst_full", s_full_o, 0);
    chk("rst_err", s_err_o, 0);
    chk("rst_ready", s_aw_ready_o, 1);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // Aux bypass with reservation.
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd5);
    aux_todo.push_back({5'd5, 32'hDEADBEEF});
    idle(1);
    chk("t2_ready_after_bypass", s_aw_ready_o, 1);
    idle(2);
    chk("t2_busy5_cleared", s_busy_o[5], 0);

    // Priority and queueing.
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd10);
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd11);
    aux_todo.push_back({5'd10, 32'h0000000A});
    aux_todo.push_back({5'd11, 32'h0000000B});
    for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0);
    idle(4);

    // Full FIFO under a sustained pipeline stream.
    for (int i = 12; i <= 16; i++) cycle(1'b0, 5'd0, '0, 1'b1, 5'(i));
    for (int i = 12; i <= 16; i++) aux_todo.push_back({5'(i), $urandom()});
    for (int i = 1; i <= 6; i++) cycle(1'b1, 5'(i), $urandom(), 1'b0, 5'd0);
    idle(10);

    // Randomized legal traffic.
    for (int n = 0; n < 400; n++) begin
      logic       rsv;
      logic [4:0] ra;
      rsv = 1'b0;
      ra  = 5'd0;
      if ($urandom_range(0, 2) == 0) begin
        r = 5'($urandom_range(17, 31));
        if (!busy_nx[r]) begin
          rsv = 1'b1;
          ra  = r;
        end
      end
      if (rsv_list.size() > 0 && aux_todo.size() == 0 && !aux_pend &&
          $urandom_range(0, 1) == 1)
        aux_todo.push_back({rsv_list.pop_front(), $urandom()});
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), $urandom(), rsv, ra);
      if (rsv) rsv_list.push_back(ra);
    end
    idle(12);
    chk("rand_no_err", s_err_o, 0);

    // x0, same-cycle set+clear, double reservation.
    cycle(1'b1, 5'd0, 32'h1, 1'b0, 5'd0);
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd8);
    idle(1);
    aux_todo.push_back({5'd8, 32'h88});
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd8);
    idle(1);
    chk("t5_busy8_set_clear", s_busy_o[8], 1);
    chk("t5_err_still_0", s_err_o, 0);
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd7);
    cycle(1'b0, 5'd0, '0, 1'b1, 5'd7);
    idle(2);
    chk("t5_err_double_rsv", s_err_o, 1);
    idle(3);
    chk("t5_err_sticky", s_err_o, 1);

    // Asynchronous reset with three queued entries.
    for (int i = 20; i <= 22; i++) cycle(1'b0, 5'd0, '0, 1'b1, 5'(i));
    for (int i = 20; i <= 22; i++) aux_todo.push_back({5'(i), $urandom()});
    for (int i = 1; i <= 3; i++) cycle(1'b1, 5'(i), $urandom(), 1'b0, 5'd0);
    @(posedge clk); #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    s_pw_we_i = 1'b0; s_aw_valid_i = 1'b0; s_rsv_i = 1'b0;
    #1;
    chk("t6_we", s_wb_we_o, 0);
    chk("t6_add", s_wb_add_o, 0);
    chk("t6_val", s_wb_val_o, 0);
    chk("t6_busy", s_busy_o, 0);
    chk("t6_full", s_full_o, 0);
    chk("t6_err", s_err_o, 0);
    chk("t6_ready", s_aw_ready_o, 1);
    mq.delete(); exp_q.delete(); aux_todo.delete(); rsv_list.delete();
    aux_pend = 1'b0;
    busy_m = '0; busy_nx = '0; err_m = 1'b0; err_nx = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(8);
    chk("t6_busy_after", s_busy_o, 0);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
